combo_lock_fsm: RTL and testbench
=================================

// Module: combo_lock_fsm
// PURPOSE
//  Combination-lock controller fed by the two edge_detect instances (NEXT, ENTER button pulses).
//  Builds a DIGITS-long code one decimal digit at a time, compares it with CODE, and drives
//  unlocked/error/lockout indicators to PMOD LEDs.
//  Runs on the design's slow clock shared with edge_detect. Inputs are one-cycle pulses in that domain.
// PARAMETERS
//  DIGITS        4        number of digits per attempt (1..8)
//  CODE          16'h1234 secret, DIGITS BCD nibbles, first-entered digit in MS nibble
//  FAIL_CYCLES   8        cycles error is held after a wrong code (>=1)
//  MAX_TRIES     3        consecutive wrong codes before lockout (>=1)
//  LOCKOUT_CYCLES 64      cycles buttons are ignored during lockout (>=1)
//  OPEN_CYCLES   32       auto-relock time, used only with COMBO_LOCK_AUTO_RELOCK_EN
// PORTS
//  clk         in   1         slow clock, all logic on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  next_pulse  in   1         one-cycle pulse: advance current digit
//  enter_pulse in   1         one-cycle pulse: commit digit / relock
//  digit       out  4         current digit value 0..9 (BCD)
//  digit_idx   out  3         index of digit being entered, 0..DIGITS-1
//  unlocked    out  1         high while in OPEN
//  error       out  1         high while in FAIL
//  locked_out  out  1         high while in LOCKOUT
//  fail_count  out  2         consecutive wrong attempts, saturates at MAX_TRIES
// BEHAVIOUR
//  Reset (async, rst_n=0): state ENTRY, digit=0, digit_idx=0, shift reg=0, fail_count=0,
//   unlocked=error=locked_out=0. All outputs registered. Reset mid-attempt discards partial code.
//  States: ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
//  ENTRY: next_pulse -> digit<=digit+1, 9 wraps to 0.
//   enter_pulse -> shift digit into code reg {reg[4*DIGITS-5:0],digit}, digit<=0;
//   if digit_idx==DIGITS-1 -> digit_idx<=0, go CHECK; else digit_idx<=digit_idx+1.
//   next_pulse and enter_pulse same cycle: enter wins, next ignored (value pre-increment is committed).
//  CHECK (exactly 1 cycle, pulses ignored): reg==CODE -> OPEN, fail_count<=0;
//   else fail_count<=fail_count+1; if new count==MAX_TRIES -> LOCKOUT else FAIL.
//   Latency: result visible 2 cycles after final enter_pulse.
//  OPEN: unlocked=1; next ignored; enter_pulse -> ENTRY (relock), code reg cleared.
//  FAIL: error=1 for exactly FAIL_CYCLES cycles, all pulses ignored, then ENTRY.
//  LOCKOUT: locked_out=1 for exactly LOCKOUT_CYCLES cycles, pulses ignored,
//   then ENTRY with fail_count<=0.
//  Wait counter: one shared down-counter, width clog2(max cycles param)+1, loaded on state entry.
//  Digit entry ignored outside ENTRY; digit/digit_idx hold 0 outside ENTRY.
// CONFIGURATION
//  COMBO_LOCK_AUTO_RELOCK_EN defined: OPEN also exits to ENTRY after OPEN_CYCLES cycles
//   with no enter_pulse; enter_pulse still relocks immediately.
//  Undefined: OPEN persists until enter_pulse; OPEN_CYCLES unused, no counter logic for it.
// TESTING (DIGITS=4, CODE=16'h1234, FAIL_CYCLES=8, MAX_TRIES=3, LOCKOUT_CYCLES=64)
//  Reset mid-entry after 2 digits -> all outputs 0, next attempt starts at digit_idx=0.
//  Enter 1,2,3,4 (n next pulses + enter each) -> unlocked=1 two cycles after 4th enter, fail_count=0.
//  Enter 1,2,3,5 -> error=1 for 8 cycles, fail_count=1, then ENTRY; pulses during FAIL ignored.
//  10 next pulses then enter -> digit wraps to 0, 0 committed; next+enter same cycle commits old digit.
//  3 wrong codes -> locked_out=1 for 64 cycles, correct code during lockout ignored, then fail_count=0.
//  OPEN then enter -> unlocked=0 next cycle; with macro, no enter -> unlocked drops after 32 cycles.

Source files
------------

// File: rtl/combo_lock_fsm.sv
// Combination-lock controller: builds a DIGITS-long BCD code from NEXT/ENTER pulses and checks it.
// Optional auto-relock from OPEN after OPEN_CYCLES is enabled by defining COMBO_LOCK_AUTO_RELOCK_EN.
module combo_lock_fsm #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] CODE           = 16'h1234,
    parameter int                  FAIL_CYCLES    = 8,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCKOUT_CYCLES = 64,
    parameter int                  OPEN_CYCLES    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       next_pulse,
    input  logic       enter_pulse,
    output logic [3:0] digit,
    output logic [2:0] digit_idx,
    output logic       unlocked,
    output logic       error,
    output logic       locked_out,
    output logic [1:0] fail_count
);
    // state   | meaning
    // ENTRY   | collecting digits
    // CHECK   | one-cycle compare of collected code against CODE
    // OPEN    | unlocked, waiting for relock
    // FAIL    | error shown for FAIL_CYCLES, buttons ignored
    // LOCKOUT | too many wrong codes, buttons ignored for LOCKOUT_CYCLES
    localparam logic [2:0] S_ENTRY   = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;

    localparam int MAX_A    = (FAIL_CYCLES > LOCKOUT_CYCLES) ? FAIL_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_WAIT = (OPEN_CYCLES > MAX_A) ? OPEN_CYCLES : MAX_A;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_digit;
    logic [2:0]          r_idx;
    logic [4*DIGITS-1:0] r_code;
    logic [4*DIGITS-1:0] w_code_shift;
    logic [1:0]          r_fail;
    logic [2:0]          w_fail_inc;
    logic                w_fail_max;
    logic                r_unlocked;
    logic                r_error;
    logic                r_locked;

    generate
        if (DIGITS == 1) begin : g_one
            assign w_code_shift = r_digit;
        end else begin : g_many
            assign w_code_shift = {r_code[4*DIGITS-5:0], r_digit};
        end
    endgenerate

    assign w_fail_inc = {1'b0, r_fail} + 3'd1;
    assign w_fail_max = (int'(w_fail_inc) >= MAX_TRIES);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ENTRY:   if (enter_pulse && (r_idx == 3'(DIGITS - 1))) w_next = S_CHECK;
            S_CHECK:   if (r_code == CODE)  w_next = S_OPEN;
                       else if (w_fail_max) w_next = S_LOCKOUT;
                       else                 w_next = S_FAIL;
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
            S_OPEN:    if (enter_pulse || (r_cnt == '0)) w_next = S_ENTRY;
`else
            S_OPEN:    if (enter_pulse) w_next = S_ENTRY;
`endif
            S_FAIL:    if (r_cnt == '0) w_next = S_ENTRY;
            S_LOCKOUT: if (r_cnt == '0) w_next = S_ENTRY;
            default:   w_next = S_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_ENTRY;
            r_cnt      <= '0;
            r_digit    <= 4'd0;
            r_idx      <= 3'd0;
            r_code     <= '0;
            r_fail     <= 2'd0;
            r_unlocked <= 1'b0;
            r_error    <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_unlocked <= (w_next == S_OPEN);
            r_error    <= (w_next == S_FAIL);
            r_locked   <= (w_next == S_LOCKOUT);

            // Counter is loaded with N-1 so the state is held for exactly N cycles
            if (w_next != r_state) begin
                case (w_next)
                    S_FAIL:    r_cnt <= CW'(FAIL_CYCLES - 1);
                    S_LOCKOUT: r_cnt <= CW'(LOCKOUT_CYCLES - 1);
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
                    S_OPEN:    r_cnt <= CW'(OPEN_CYCLES - 1);
`endif
                    default:   r_cnt <= '0;
                endcase
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            case (r_state)
                S_ENTRY: begin
                    if (enter_pulse) begin
                        r_code  <= w_code_shift;
                        r_digit <= 4'd0;
                        r_idx   <= (r_idx == 3'(DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
                    end else if (next_pulse) begin
                        r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (r_code == CODE) r_fail <= 2'd0;
                    else if (w_fail_max) r_fail <= 2'(MAX_TRIES);
                    else r_fail <= w_fail_inc[1:0];
                end
                S_LOCKOUT: if (w_next == S_ENTRY) r_fail <= 2'd0;
                default: ;
            endcase

            if ((w_next == S_ENTRY) && (r_state != S_ENTRY)) r_code <= '0;
        end
    end

    assign digit      = r_digit;
    assign digit_idx  = r_idx;
    assign unlocked   = r_unlocked;
    assign error      = r_error;
    assign locked_out = r_locked;
    assign fail_count = r_fail;
endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed testbench for combo_lock_fsm (DIGITS=4, CODE=16'h1234).
module tb_combo_lock_fsm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       next_pulse = 1'b0;
    logic       enter_pulse = 1'b0;
    logic [3:0] digit;
    logic [2:0] digit_idx;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [1:0] fail_count;

    int total = 0;
    int passed = 0;

    combo_lock_fsm #(
        .DIGITS(4), .CODE(16'h1234), .FAIL_CYCLES(8), .MAX_TRIES(3),
        .LOCKOUT_CYCLES(64), .OPEN_CYCLES(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .next_pulse(next_pulse), .enter_pulse(enter_pulse),
        .digit(digit), .digit_idx(digit_idx), .unlocked(unlocked), .error(error),
        .locked_out(locked_out), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic press(input logic n, input logic e);
        tick();
        next_pulse = n; enter_pulse = e;
        tick();
        next_pulse = 1'b0; enter_pulse = 1'b0;
    endtask

    task automatic enter_digit(input int d);
        repeat (d) press(1'b1, 1'b0);
        press(1'b0, 1'b1);
    endtask

    task automatic enter_code(input int a, input int b, input int c, input int d);
        enter_digit(a); enter_digit(b); enter_digit(c); enter_digit(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        total++; if ({digit, digit_idx, unlocked, error, locked_out, fail_count} !== 12'd0)
            $display("FAIL reset_outputs: got %h required 0", {digit, digit_idx, unlocked, error, locked_out, fail_count});
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        tick();
        total++; if (digit_idx !== 3'd0 || digit !== 4'd0)
            $display("FAIL reset_release: got digit %0d idx %0d required 0 0", digit, digit_idx);
        else passed++;
    endtask

    task automatic test_open();
        enter_code(1, 2, 3, 4);
        total++; if (unlocked !== 1'b0)
            $display("FAIL open_check_cycle: got unlocked %0b required 0", unlocked);
        else passed++;
        tick();
        total++; if (unlocked !== 1'b1 || fail_count !== 2'd0 || error !== 1'b0)
            $display("FAIL open_unlock: got unlocked %0b fail %0d err %0b required 1 0 0", unlocked, fail_count, error);
        else passed++;
        press(1'b1, 1'b0);
        total++; if (digit !== 4'd0 || digit_idx !== 3'd0 || unlocked !== 1'b1)
            $display("FAIL open_next_ignored: got digit %0d idx %0d unl %0b required 0 0 1", digit, digit_idx, unlocked);
        else passed++;
        press(1'b0, 1'b1);
        total++; if (unlocked !== 1'b0)
            $display("FAIL open_relock: got unlocked %0b required 0", unlocked);
        else passed++;
    endtask

    task automatic test_fail();
        int bad;
        bad = 0;
        enter_code(1, 2, 3, 5);
        tick();
        total++; if (error !== 1'b1 || fail_count !== 2'd1 || unlocked !== 1'b0)
            $display("FAIL fail_enter: got err %0b fail %0d unl %0b required 1 1 0", error, fail_count, unlocked);
        else passed++;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (error !== 1'b1) bad++;
            next_pulse  = (i < 7) && (i % 2 == 1);
            enter_pulse = (i == 4);
        end
        next_pulse = 1'b0; enter_pulse = 1'b0;
        total++; if (bad != 0)
            $display("FAIL fail_hold: got %0d cycles without error required 0", bad);
        else passed++;
        tick();
        total++; if (error !== 1'b0 || digit !== 4'd0 || digit_idx !== 3'd0 || fail_count !== 2'd1)
            $display("FAIL fail_exit: got err %0b digit %0d idx %0d fail %0d required 0 0 0 1", error, digit, digit_idx, fail_count);
        else passed++;
    endtask

    task automatic test_reset_mid_entry();
        enter_digit(1); enter_digit(2);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        total++; if (digit_idx !== 3'd2 || digit !== 4'd2)
            $display("FAIL mid_entry_progress: got idx %0d digit %0d required 2 2", digit_idx, digit);
        else passed++;
        rst_n = 1'b0;
        #2;
        total++; if ({digit, digit_idx, unlocked, error, locked_out, fail_count} !== 12'd0)
            $display("FAIL mid_entry_reset: got %h required 0", {digit, digit_idx, unlocked, error, locked_out, fail_count});
        else passed++;
        @(negedge clk); rst_n = 1'b1;
        enter_code(1, 2, 3, 4);
        tick();
        total++; if (unlocked !== 1'b1)
            $display("FAIL mid_entry_fresh_attempt: got unlocked %0b required 1", unlocked);
        else passed++;
        press(1'b0, 1'b1);
    endtask

    task automatic test_wrap_and_simultaneous();
        repeat (9) press(1'b1, 1'b0);
        total++; if (digit !== 4'd9)
            $display("FAIL wrap_nine: got %0d required 9", digit);
        else passed++;
        press(1'b1, 1'b0);
        total++; if (digit !== 4'd0)
            $display("FAIL wrap_zero: got %0d required 0", digit);
        else passed++;
        press(1'b0, 1'b1);
        total++; if (digit_idx !== 3'd1)
            $display("FAIL wrap_commit_idx: got %0d required 1", digit_idx);
        else passed++;
        enter_digit(2); enter_digit(3); enter_digit(4);
        tick();
        total++; if (error !== 1'b1 || fail_count !== 2'd1)
            $display("FAIL wrap_zero_committed: got err %0b fail %0d required 1 1", error, fail_count);
        else passed++;
        repeat (10) tick();
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        total++; if (digit !== 4'd0 || digit_idx !== 3'd1)
            $display("FAIL simul_enter_wins: got digit %0d idx %0d required 0 1", digit, digit_idx);
        else passed++;
        enter_digit(2); enter_digit(3); enter_digit(4);
        tick();
        total++; if (unlocked !== 1'b1 || fail_count !== 2'd0)
            $display("FAIL simul_old_digit_committed: got unl %0b fail %0d required 1 0", unlocked, fail_count);
        else passed++;
        press(1'b0, 1'b1);
    endtask

    task automatic test_lockout();
        int bad;
        bad = 0;
        enter_code(9, 9, 9, 9); repeat (10) tick();
        enter_code(0, 0, 0, 0); repeat (10) tick();
        total++; if (fail_count !== 2'd2)
            $display("FAIL lockout_two_wrong: got fail %0d required 2", fail_count);
        else passed++;
        enter_code(4, 3, 2, 1);
        tick();
        total++; if (locked_out !== 1'b1 || error !== 1'b0 || fail_count !== 2'd3)
            $display("FAIL lockout_enter: got lo %0b err %0b fail %0d required 1 0 3", locked_out, error, fail_count);
        else passed++;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (locked_out !== 1'b1 || unlocked !== 1'b0) bad++;
            next_pulse  = (i < 62) && (i % 3 != 0);
            enter_pulse = (i < 62) && (i % 3 == 0);
        end
        next_pulse = 1'b0; enter_pulse = 1'b0;
        total++; if (bad != 0)
            $display("FAIL lockout_hold: got %0d bad cycles required 0", bad);
        else passed++;
        tick();
        total++; if (locked_out !== 1'b0 || fail_count !== 2'd0 || digit !== 4'd0 || digit_idx !== 3'd0)
            $display("FAIL lockout_exit: got lo %0b fail %0d digit %0d idx %0d required 0 0 0 0", locked_out, fail_count, digit, digit_idx);
        else passed++;
        enter_code(1, 2, 3, 4);
        tick();
        total++; if (unlocked !== 1'b1)
            $display("FAIL lockout_then_open: got unlocked %0b required 1", unlocked);
        else passed++;
        press(1'b0, 1'b1);
    endtask

    task automatic test_open_persistence();
        int bad;
        bad = 0;
        enter_code(1, 2, 3, 4);
        tick();
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
        for (int i = 1; i <= 31; i++) begin
            tick();
            if (unlocked !== 1'b1) bad++;
        end
        total++; if (bad != 0)
            $display("FAIL autorelock_hold: got %0d bad cycles required 0", bad);
        else passed++;
        tick();
        total++; if (unlocked !== 1'b0)
            $display("FAIL autorelock_drop: got unlocked %0b required 0", unlocked);
        else passed++;
`else
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (unlocked !== 1'b1) bad++;
        end
        total++; if (bad != 0)
            $display("FAIL open_persist: got %0d bad cycles required 0", bad);
        else passed++;
        press(1'b0, 1'b1);
        total++; if (unlocked !== 1'b0)
            $display("FAIL open_persist_relock: got unlocked %0b required 0", unlocked);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_open();
        test_fail();
        test_reset_mid_entry();
        test_wrap_and_simultaneous();
        test_lockout();
        test_open_persistence();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
